// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: opcodes, register indices and FSM states for regfile_access_ctrl
package regfile_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_MOVR = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_CMP  = 3'd7
  } opcode_e;
  localparam logic [1:0] AX = 2'd0;
  localparam logic [1:0] BX = 2'd1;
  localparam logic [1:0] CX = 2'd2;
  localparam logic [1:0] DX = 2'd3;
  typedef enum logic [1:0] {IDLE, RD_S, RD_D, WB} state_e;
endpackage

// File: rtl/rfc_alu.sv
// rfc_alu: combinational ALU, b is the dst operand, a the src operand
module rfc_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  opcode_e       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          zf_n,
  output logic          cf_n
);
  logic [DW:0] sum, diff;
  // result select; the extra top bit of sum/diff is carry/borrow
  always_comb begin
    sum  = {1'b0, b} + {1'b0, a};
    diff = {1'b0, b} - {1'b0, a};
    res  = op == OP_ADD ? sum[DW-1:0] :
           (op == OP_SUB || op == OP_CMP) ? diff[DW-1:0] :
           op == OP_AND ? (b & a) :
           op == OP_OR  ? (b | a) :
           op == OP_XOR ? (b ^ a) : b;
    cf_n = op == OP_ADD ? sum[DW] : (op == OP_SUB || op == OP_CMP) ? diff[DW] : 1'b0;
    zf_n = res == '0;
  end
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences register-file reads, runs the ALU op and writes back.
// Define RFC_OP_BUF_EN to place a 2-entry op FIFO in front of the FSM.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RSEL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [RSEL_W-1:0] op_dst,
  input  logic [RSEL_W-1:0] op_src,
  input  logic [DW-1:0]     op_imm,
  output logic [RSEL_W-1:0] rf_sel,
  output logic              rf_we,
  output logic [DW-1:0]     rf_wdata,
  input  logic [DW-1:0]     rf_rdata,
  output logic              res_valid,
  output logic [DW-1:0]     res_data,
  output logic              zf,
  output logic              cf
);
  state_e              state_q;
  opcode_e             code_q;
  logic [RSEL_W-1:0]   dst_q, src_q;
  logic [DW-1:0]       a_q;
  logic                take;
  logic [2:0]          t_code;
  logic [RSEL_W-1:0]   t_dst, t_src;
  logic [DW-1:0]       t_imm;
  logic [DW-1:0]       alu_res;
  logic                alu_zf, alu_cf;
`ifdef RFC_OP_BUF_EN
  localparam int OW = 3 + 2 * RSEL_W + DW;
  logic [OW-1:0] fifo_q [2];
  logic          rd_q, wr_q, push, pop;
  logic [1:0]    cnt_q;
  assign op_ready = cnt_q != 2'd2;
  assign push     = op_valid && op_ready;
  assign pop      = state_q == IDLE && cnt_q != 2'd0;
  assign take     = pop;
  assign {t_code, t_dst, t_src, t_imm} = fifo_q[rd_q];
  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  // FIFO storage, no reset needed since occupancy gates reads
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q] <= {op_code, op_dst, op_src, op_imm};
`else
  assign op_ready = state_q == IDLE;
  assign take     = op_valid && op_ready;
  assign {t_code, t_dst, t_src, t_imm} = {op_code, op_dst, op_src, op_imm};
`endif
  rfc_alu #(.DW(DW)) u_alu (
    .op   (code_q),
    .a    (a_q),
    .b    (rf_rdata),
    .res  (alu_res),
    .zf_n (alu_zf),
    .cf_n (alu_cf)
  );
  // FSM with outputs registered on entry to each state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      code_q    <= OP_MOVI;
      dst_q     <= '0;
      src_q     <= '0;
      a_q       <= '0;
      rf_sel    <= '0;
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      rf_wdata  <= '0;
      res_valid <= 1'b0;
      case (state_q)
        IDLE:
          if (take) begin
            code_q <= opcode_e'(t_code);
            dst_q  <= t_dst;
            src_q  <= t_src;
            if (opcode_e'(t_code) == OP_MOVI) begin
              state_q   <= WB;
              rf_sel    <= t_dst;
              rf_we     <= 1'b1;
              rf_wdata  <= t_imm;
              res_valid <= 1'b1;
              res_data  <= t_imm;
            end else begin
              state_q <= RD_S;
              rf_sel  <= t_src;
            end
          end
        RD_S: begin
          a_q    <= rf_rdata;
          rf_sel <= dst_q;
          if (code_q == OP_MOVR) begin
            state_q   <= WB;
            rf_we     <= 1'b1;
            rf_wdata  <= rf_rdata;
            res_valid <= 1'b1;
            res_data  <= rf_rdata;
          end else state_q <= RD_D;
        end
        RD_D: begin
          state_q   <= WB;
          rf_we     <= code_q != OP_CMP;
          rf_wdata  <= alu_res;
          res_valid <= 1'b1;
          res_data  <= alu_res;
          zf        <= alu_zf;
          cf        <= alu_cf;
        end
        WB: begin
          state_q <= IDLE;
          rf_sel  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
